// File: rtl/wb_retire_queue.sv
// In-order write-back retire queue: buffers MEM results, commits the head to RF/CSR,
// raises exception/ertn/refetch flushes and forwards queued RF writes to ID.
module wb_retire_queue #(
  parameter int DEPTH = 4,
  parameter int NRP   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [199:0]      in_bus,
  input  logic              commit_stall,
  output logic              csr_re,
  output logic              csr_we,
  output logic [13:0]       csr_num,
  output logic [31:0]       csr_wmask,
  output logic [31:0]       csr_wvalue,
  input  logic [31:0]       csr_rvalue,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              wb_ex,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [31:0]       wb_ex_pc,
  output logic [31:0]       wb_vaddr,
  output logic              ertn_flush,
  output logic              refetch_flush,
  output logic              flush,
  output logic [31:0]       flush_entry,
  input  logic [5*NRP-1:0]  fwd_raddr,
  output logic [NRP-1:0]    fwd_hit,
  output logic [NRP-1:0]    fwd_busy,
  output logic [32*NRP-1:0] fwd_data,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata,
  output logic [63:0]       retire_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] vaddr;
    logic        refetch;
  } entry_t;

  entry_t        q [DEPTH];
  entry_t        hd;
  entry_t        in_e;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          empty;
  logic          push;
  logic          commit;

  assign hd       = q[head];
  assign empty    = (count == '0);
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign commit   = ~empty & ~commit_stall;
  assign push     = in_valid & in_ready & ~flush;

  // An excepting instruction must never write the register file.
  always_comb begin
    in_e = entry_t'(in_bus);
    if (in_e.ex) in_e.rf_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (push) q[tail] <= in_e;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)   tail <= tail + 1'b1;
        if (commit) head <= head + 1'b1;
        if (push && !commit)      count <= count + 1'b1;
        else if (!push && commit) count <= count - 1'b1;
      end
      if (commit && !hd.ex) retire_cnt <= retire_cnt + 64'd1;
    end
  end

  assign rf_we         = commit & ~hd.ex & hd.rf_we;
  assign rf_waddr      = hd.rf_waddr;
  assign rf_wdata      = hd.csr_re ? csr_rvalue : hd.rf_wdata;
  assign csr_re        = commit & (hd.csr_re | hd.ex | hd.ertn);
  assign csr_we        = commit & ~hd.ex & hd.csr_we;
  assign csr_num       = hd.ex ? 14'h00C : (hd.ertn ? 14'h006 : hd.csr_num);
  assign csr_wmask     = hd.csr_wmask;
  assign csr_wvalue    = hd.csr_wvalue;

  assign wb_ex         = commit & hd.ex;
  assign wb_ecode      = hd.ecode;
  assign wb_esubcode   = hd.esubcode;
  assign wb_ex_pc      = hd.pc;
  assign wb_vaddr      = hd.vaddr;
  assign ertn_flush    = commit & hd.ertn & ~hd.ex;
  assign refetch_flush = commit & hd.refetch & ~hd.ex & ~hd.ertn;
  assign flush         = wb_ex | ertn_flush | refetch_flush;
  // EENTRY/ERA arrive through csr_rvalue; a refetch restarts at the next instruction.
  assign flush_entry   = !flush ? 32'h0 : ((hd.ex | hd.ertn) ? csr_rvalue : hd.pc + 32'd4);

  assign debug_wb_pc       = hd.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  logic [4:0]    raddr;
  logic [AW-1:0] idx;

  // Scan oldest to youngest so the last (youngest) match wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_busy = '0;
    fwd_data = '0;
    raddr    = '0;
    idx      = '0;
    for (int p = 0; p < NRP; p++) begin
      raddr = fwd_raddr[5*p +: 5];
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + AW'(k);
        if ((AW+1)'(k) < count && q[idx].rf_we && q[idx].rf_waddr == raddr && raddr != 5'd0) begin
          fwd_hit[p]           = 1'b1;
          fwd_busy[p]          = q[idx].csr_re;
          fwd_data[32*p +: 32] = q[idx].rf_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue (DEPTH=4, NRP=2) with hand-computed expectations.
module tb_wb_retire_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [199:0] in_bus;
  logic        commit_stall;
  logic        csr_re, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_ex_pc, wb_vaddr;
  logic        ertn_flush, refetch_flush, flush;
  logic [31:0] flush_entry;
  logic [9:0]  fwd_raddr;
  logic [1:0]  fwd_hit, fwd_busy;
  logic [63:0] fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [63:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_retire_queue #(.DEPTH(4), .NRP(2)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
    .commit_stall(commit_stall), .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .flush(flush), .flush_entry(flush_entry), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit),
    .fwd_busy(fwd_busy), .fwd_data(fwd_data), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd, input logic cre, input logic ertn,
                                      input logic ex, input logic [5:0] ec, input logic rft);
    return {pc, we, wa, wd, cre, 1'b0, 14'h001, 32'hFFFF_FFFF, 32'h0,
            ertn, ex, ec, 9'h0, pc + 32'h100, rft};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [199:0] b);
    in_valid = 1'b1;
    in_bus   = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, committed, cyc;
    resetn = 1'b0; in_valid = 1'b0; in_bus = '0; commit_stall = 1'b0;
    csr_rvalue = 32'h0; fwd_raddr = '0;
    tick(); tick();
    resetn = 1'b1;
    fwd_raddr = {5'd3, 5'd1};
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_csr_re", csr_re, 0);
    check("rst_flush", flush, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    tick();

    // Fill under stall, then drain in order
    commit_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push1(mk(32'h1C00_0000 + 32'(4*i), 1'b1, 5'(i+1), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 6'h0, 1'b0));
      if (i == 2) check("fill3_in_ready", in_ready, 1);
    end
    fwd_raddr = {5'd0, 5'd2};
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_fwd_hit", fwd_hit, 2'b01);
    check("full_fwd_data", fwd_data[31:0], 32'h101);
    check("stall_rf_we", rf_we, 0);
    tick();
    commit_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_pc", debug_wb_pc, 32'h1C00_0000 + 32'(4*i));
      check("drain_we", debug_wb_rf_we, 4'hF);
      check("drain_wdata", rf_wdata, 32'h100 + 32'(i));
      tick();
    end
    @(negedge clk);
    check("drain_in_ready", in_ready, 1);
    check("drain_retire", retire_cnt, 4);
    check("empty_rf_we", rf_we, 0);
    tick();

    // Forwarding: youngest wins, csr_re busy, r0 never hits
    commit_stall = 1'b1;
    push1(mk(32'h1C00_0100, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0));
    push1(mk(32'h1C00_0104, 1'b1, 5'd5, 32'h22, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0));
    push1(mk(32'h1C00_0108, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0, 6'h0, 1'b0));
    fwd_raddr = {5'd7, 5'd5};
    csr_rvalue = 32'hABCD_0000;
    @(negedge clk);
    check("fwd_hit_57", fwd_hit, 2'b11);
    check("fwd_busy_57", fwd_busy, 2'b10);
    check("fwd_data_r5", fwd_data[31:0], 32'h22);
    fwd_raddr = {5'd9, 5'd0};
    #1;
    check("fwd_hit_09", fwd_hit, 2'b00);
    check("fwd_data_09", fwd_data, 64'h0);
    tick();
    commit_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fwdq_wdata", rf_wdata, i == 0 ? 32'h11 : (i == 1 ? 32'h22 : 32'hABCD_0000));
      check("fwdq_csr_re", csr_re, i == 2 ? 1 : 0);
      tick();
    end
    check("fwdq_retire", retire_cnt, 7);

    // Exception at head with three younger entries behind it
    commit_stall = 1'b1;
    push1(mk(32'h1C00_0020, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b1, 6'h0B, 1'b0));
    for (int i = 0; i < 3; i++)
      push1(mk(32'h1C00_0024 + 32'(4*i), 1'b1, 5'(10+i), 32'h44, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0));
    fwd_raddr = {5'd0, 5'd3};
    csr_rvalue = 32'h1C00_8000;
    @(negedge clk);
    check("ex_fwd_cleared", fwd_hit, 0);
    tick();
    commit_stall = 1'b0;
    @(negedge clk);
    check("ex_wb_ex", wb_ex, 1);
    check("ex_ecode", wb_ecode, 6'h0B);
    check("ex_csr_num", csr_num, 14'h00C);
    check("ex_csr_re", csr_re, 1);
    check("ex_flush_entry", flush_entry, 32'h1C00_8000);
    check("ex_rf_we", rf_we, 0);
    check("ex_pc", wb_ex_pc, 32'h1C00_0020);
    check("ex_vaddr", wb_vaddr, 32'h1C00_0120);
    tick();
    @(negedge clk);
    check("ex_after_ready", in_ready, 1);
    check("ex_after_wb_ex", wb_ex, 0);
    check("ex_after_flush", flush, 0);
    check("ex_after_retire", retire_cnt, 7);
    tick();

    // Refetch at head; the same-cycle push must be dropped
    commit_stall = 1'b1;
    push1(mk(32'h1C00_0010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h0, 1'b1));
    commit_stall = 1'b0;
    in_valid = 1'b1;
    in_bus = mk(32'h1C00_0099, 1'b1, 5'd4, 32'h99, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0);
    @(negedge clk);
    check("rf_flush", flush, 1);
    check("rf_refetch_flush", refetch_flush, 1);
    check("rf_flush_entry", flush_entry, 32'h1C00_0014);
    check("rf_csr_re", csr_re, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rf_dropped_push", rf_we, 0);
    check("rf_after_flush", flush, 0);
    check("rf_retire", retire_cnt, 8);
    tick();

    // ertn at head
    commit_stall = 1'b1;
    push1(mk(32'h1C00_0040, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h0, 1'b0));
    commit_stall = 1'b0;
    csr_rvalue = 32'h1C00_3000;
    @(negedge clk);
    check("ertn_flush", ertn_flush, 1);
    check("ertn_csr_num", csr_num, 14'h006);
    check("ertn_csr_re", csr_re, 1);
    check("ertn_flush_entry", flush_entry, 32'h1C00_3000);
    tick();

    // Streaming through a full queue; pointers wrap three times
    pushed = 0; committed = 0; cyc = 0;
    commit_stall = 1'b1;
    in_valid = 1'b1;
    in_bus = mk(32'h2000_0000, 1'b1, 5'd1, 32'h5000, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0);
    while (committed < 12 && cyc < 200) begin
      @(negedge clk);
      if (rf_we) begin
        check("stream_pc", debug_wb_pc, 32'h2000_0000 + 32'(4*committed));
        check("stream_wdata", rf_wdata, 32'h5000 + 32'(committed));
        committed++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
      cyc++;
      commit_stall = (cyc < 4);
      in_valid = (pushed < 12);
      in_bus = mk(32'h2000_0000 + 32'(4*pushed), 1'b1, 5'((pushed % 31) + 1),
                  32'h5000 + 32'(pushed), 1'b0, 1'b0, 1'b0, 6'h0, 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_commits", 64'(committed), 12);
    check("stream_retire", retire_cnt, 21);
    check("stream_in_ready", in_ready, 1);
    check("stream_drained", rf_we, 0);
    tick();

    // Reset with entries pending discards them
    commit_stall = 1'b1;
    push1(mk(32'h3000_0000, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0));
    push1(mk(32'h3000_0004, 1'b1, 5'd6, 32'h67, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    commit_stall = 1'b0;
    fwd_raddr = {5'd0, 5'd6};
    @(negedge clk);
    check("rst2_retire", retire_cnt, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_rf_we", rf_we, 0);
    check("rst2_fwd", fwd_hit, 0);
    tick();
    @(negedge clk);
    check("rst2_no_commit", rf_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
